// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared types and constants for the wave bank loader
package wave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } load_state_t;

  localparam int DEFAULT_DEPTH        = 512;
  localparam int DEFAULT_SAMPLE_WIDTH = 16;
  localparam int READ_LATENCY         = 2;

endpackage

// File: rtl/wave_bank.sv
// rtl/wave_bank.sv - one ping-pong wave buffer with bank select, width and qualified read pipe
module wave_bank
  import wave_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int WAVE_DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH   = $clog2(WAVE_DEPTH)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  input  logic                    swap,
  input  logic [ADDR_WIDTH:0]     swap_width,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_index,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]     width
);

  logic                    bank_sel;
  logic                    qual_s1;
  logic                    qual_s2;
  logic [ADDR_WIDTH:0]     rd_addr_s1;
  logic [SAMPLE_WIDTH-1:0] ram_q;

  // Bank select and active width change together, only when a load completes.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      bank_sel <= 1'b0;
      width    <= '0;
    end else if (swap) begin
      bank_sel <= ~bank_sel;
      width    <= swap_width;
    end
  end

  // Address cycle: capture bank and qualifier together so one read never straddles a swap.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      qual_s1    <= 1'b0;
      rd_addr_s1 <= '0;
      qual_s2    <= 1'b0;
    end else begin
      qual_s1    <= rd_en && ({1'b0, rd_index} < width);
      rd_addr_s1 <= {bank_sel, rd_index};
      qual_s2    <= qual_s1;
    end
  end

  wave_dpram #(
    .DATA_WIDTH (SAMPLE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH + 1)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (wr_en),
    .wr_addr ({~bank_sel, wr_addr}),
    .wr_data (wr_data),
    .rd_addr (rd_addr_s1),
    .rd_data (ram_q)
  );

  assign rd_data = qual_s2 ? ram_q : '0;

endmodule

// File: rtl/wave_dpram.sv
// rtl/wave_dpram.sv - dual-port block RAM, one write port and one registered read port
module wave_dpram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_in,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Plain BRAM behaviour: write port and registered read, no reset on storage.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/wave_bank_loader.sv
// rtl/wave_bank_loader.sv - copies a wave from main RAM into oscillator and visual ping-pong banks
module wave_bank_loader
  import wave_pkg::*;
#(
  parameter int NUM_OSC      = 4,
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int WAVE_DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH   = $clog2(WAVE_DEPTH),
  parameter int SRC_LATENCY  = 2
) (
  input  logic                                  clk_in,
  input  logic                                  rst_n_in,
  input  logic                                  load_trig_in,
  input  logic [ADDR_WIDTH:0]                   load_width_in,
  input  logic [NUM_OSC-1:0]                    load_mask_in,
  output logic [ADDR_WIDTH-1:0]                 src_addr_out,
  input  logic [SAMPLE_WIDTH-1:0]               src_data_in,
  output logic                                  busy_out,
  output logic                                  done_out,
  input  logic [NUM_OSC-1:0]                    osc_is_on_in,
  input  logic [NUM_OSC-1:0][ADDR_WIDTH-1:0]    osc_index_in,
  output logic [NUM_OSC-1:0][SAMPLE_WIDTH-1:0]  osc_data_out,
  output logic [NUM_OSC-1:0][ADDR_WIDTH:0]      osc_width_out,
  input  logic [ADDR_WIDTH-1:0]                 viz_index_in,
  output logic [SAMPLE_WIDTH-1:0]               viz_data_out,
  output logic [ADDR_WIDTH:0]                   viz_width_out
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(WAVE_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] LAT_M1  = (ADDR_WIDTH + 1)'(SRC_LATENCY - 1);

  load_state_t               state;
  load_state_t               state_nxt;
  logic [ADDR_WIDTH:0]       cnt;
  logic [ADDR_WIDTH:0]       cur_width;
  logic [NUM_OSC-1:0]        cur_mask;
  logic                      pend_vld;
  logic [ADDR_WIDTH:0]       pend_width;
  logic [NUM_OSC-1:0]        pend_mask;
  logic                      trig_ok;
  logic [ADDR_WIDTH:0]       trig_width;
  logic                      start;
  logic [ADDR_WIDTH:0]       start_width;
  logic [NUM_OSC-1:0]        start_mask;
  logic [SRC_LATENCY-1:0]    wp_vld;
  logic [ADDR_WIDTH-1:0]     wp_addr [SRC_LATENCY];
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;

  // Zero-width requests are ignored; oversize requests clamp to the bank depth.
  assign trig_ok    = load_trig_in && (load_width_in != '0);
  assign trig_width = (load_width_in > DEPTH_W) ? DEPTH_W : load_width_in;

  // Load sequencing: fill addresses, drain the source latency, then swap banks.
  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    start_width = trig_width;
    start_mask  = load_mask_in;
    case (state)
      IDLE: begin
        if (trig_ok) begin
          start     = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (cnt == cur_width - ONE_W) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == LAT_M1) begin
          state_nxt = SWAP;
        end
      end
      SWAP: begin
        if (trig_ok) begin
          start     = 1'b1;
          state_nxt = FILL;
        end else if (pend_vld) begin
          start       = 1'b1;
          start_width = pend_width;
          start_mask  = pend_mask;
          state_nxt   = FILL;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Phase counter, latched request and the single-deep pending slot (latest wins).
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt        <= '0;
      cur_width  <= '0;
      cur_mask   <= '0;
      pend_vld   <= 1'b0;
      pend_width <= '0;
      pend_mask  <= '0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + ONE_W;
      if (start) begin
        cur_width <= start_width;
        cur_mask  <= start_mask;
      end
      if (state == SWAP) begin
        pend_vld <= 1'b0;
      end else if (state != IDLE && trig_ok) begin
        pend_vld   <= 1'b1;
        pend_width <= trig_width;
        pend_mask  <= load_mask_in;
      end
    end
  end

  // Valid flag travels with the read address so the write lines up with returning data.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wp_vld <= '0;
    end else begin
      wp_vld[0] <= (state == FILL);
      for (int i = 1; i < SRC_LATENCY; i++) begin
        wp_vld[i] <= wp_vld[i-1];
      end
    end
  end

  // Address delay line matching the main RAM read latency.
  always_ff @(posedge clk_in) begin
    wp_addr[0] <= cnt[ADDR_WIDTH-1:0];
    for (int i = 1; i < SRC_LATENCY; i++) begin
      wp_addr[i] <= wp_addr[i-1];
    end
  end

  assign wr_en        = wp_vld[SRC_LATENCY-1];
  assign wr_addr      = wp_addr[SRC_LATENCY-1];
  assign busy_out     = (state != IDLE);
  assign done_out     = (state == SWAP);
  assign src_addr_out = (state == FILL) ? cnt[ADDR_WIDTH-1:0] : '0;

  for (genvar g = 0; g < NUM_OSC; g++) begin : g_osc
    wave_bank #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .WAVE_DEPTH   (WAVE_DEPTH),
      .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_bank (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .wr_en      (wr_en && cur_mask[g]),
      .wr_addr    (wr_addr),
      .wr_data    (src_data_in),
      .swap       (done_out && cur_mask[g]),
      .swap_width (cur_width),
      .rd_en      (osc_is_on_in[g]),
      .rd_index   (osc_index_in[g]),
      .rd_data    (osc_data_out[g]),
      .width      (osc_width_out[g])
    );
  end

  wave_bank #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .WAVE_DEPTH   (WAVE_DEPTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_viz (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (src_data_in),
    .swap       (done_out),
    .swap_width (cur_width),
    .rd_en      (1'b1),
    .rd_index   (viz_index_in),
    .rd_data    (viz_data_out),
    .width      (viz_width_out)
  );

endmodule
